// File: rtl/ham_pkg.sv
// Shared Hamming(7,4) definitions: data/code widths, the reference encode
// function, and the delivered codeword width.
// Build option: HAM_PARITY_EN widens the delivered codeword to 8 bits by
// prepending an overall parity bit (extended SECDED code).
package ham_pkg;

  localparam int unsigned HAM_DATA_W = 4;
  localparam int unsigned HAM_CODE_W = 7;

`ifdef HAM_PARITY_EN
  localparam int unsigned HAM_CODE_OUT_W = HAM_CODE_W + 1;
`else
  localparam int unsigned HAM_CODE_OUT_W = HAM_CODE_W;
`endif

  // Hamming(7,4) encode; code[6:0] = {p1, p2, d1, p3, d2, d3, d4}
  function automatic logic [HAM_CODE_W-1:0] ham74_encode(input logic [HAM_DATA_W-1:0] data);
    logic d1, d2, d3, d4;
    logic p1, p2, p3;
    d1 = data[0];
    d2 = data[1];
    d3 = data[2];
    d4 = data[3];
    p1 = d1 ^ d2 ^ d4;
    p2 = d1 ^ d3 ^ d4;
    p3 = d2 ^ d3 ^ d4;
    return {p1, p2, d1, p3, d2, d3, d4};
  endfunction

endpackage

// File: rtl/ham_encoder.sv
// Combinational Hamming(7,4) encoder, shared datapath for the arbiter.
// Ports:
//   data   - 4-bit nibble (d1 = data[0] .. d4 = data[3])
//   code_c - 7-bit codeword {p1, p2, d1, p3, d2, d3, d4}
module ham_encoder
  import ham_pkg::*;
(
  input  logic [HAM_DATA_W-1:0] data,
  output logic [HAM_CODE_W-1:0] code_c
);

  logic d1, d2, d3, d4;
  logic p1, p2, p3;

  // Parity bits each cover three of the four data bits
  always_comb begin
    d1 = data[0];
    d2 = data[1];
    d3 = data[2];
    d4 = data[3];
    p1 = d1 ^ d2 ^ d4;
    p2 = d1 ^ d3 ^ d4;
    p3 = d2 ^ d3 ^ d4;
    code_c = {p1, p2, d1, p3, d2, d3, d4};
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// above ptr, wrapping around, when enabled.
// Ports:
//   req         - per-requester request
//   ptr         - highest-priority index this cycle (0..NUM_REQ-1)
//   en          - grant allowed this cycle
//   grant_c     - one-hot grant (all zero when disabled or idle)
//   grant_idx_c - index of the granted requester (0 when none)
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [SRC_W-1:0]   grant_idx_c
);

  // One extra bit so ptr + offset never overflows before the wrap
  localparam int unsigned SUM_W = SRC_W + 1;

  logic [SUM_W-1:0] cand;
  logic             found;

  // Scan offsets 0..NUM_REQ-1 from ptr; the first hit wins
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + SUM_W'(k);
      if (cand >= SUM_W'(NUM_REQ)) begin
        cand = cand - SUM_W'(NUM_REQ);
      end
      if (en && !found && req[SRC_W'(cand)]) begin
        grant_c[SRC_W'(cand)] = 1'b1;
        grant_idx_c           = SRC_W'(cand);
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ham_enc_arbiter.sv
// Round-robin scheduler sharing one Hamming(7,4) encoder between NUM_REQ
// nibble requesters, with a registered codeword/source output stage.
// Build option: HAM_PARITY_EN makes out_code 8 bits {overall_parity, code}.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   req_valid  - per-requester nibble valid
//   req_data   - nibble i at [4i+3:4i]
//   req_ready  - one-hot accept (combinational)
//   out_valid  - output register holds a codeword
//   out_ready  - downstream accepts the codeword
//   out_code   - encoded codeword
//   out_src    - requester index that produced out_code
//   enc_count  - delivered-codeword counter, wraps silently
module ham_enc_arbiter
  import ham_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned SRC_W   = $clog2(NUM_REQ),
  parameter  int unsigned CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*HAM_DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [HAM_CODE_OUT_W-1:0]     out_code,
  output logic [SRC_W-1:0]              out_src,
  output logic [CNT_W-1:0]              enc_count
);

  logic                      can_load_c;
  logic [NUM_REQ-1:0]        grant_c;
  logic [SRC_W-1:0]          grant_idx_c;
  logic                      grant_any_c;
  logic [HAM_DATA_W-1:0]     sel_nibble_c;
  logic [HAM_CODE_W-1:0]     code7_c;
  logic [HAM_CODE_OUT_W-1:0] code_ext_c;

  logic [SRC_W-1:0]          rr_ptr;
  logic [SRC_W-1:0]          nxt_ptr;
  logic                      nxt_valid;
  logic [HAM_CODE_OUT_W-1:0] nxt_code;
  logic [SRC_W-1:0]          nxt_src;
  logic [CNT_W-1:0]          nxt_count;

  // Register may load when empty or when it drains this same cycle
  assign can_load_c = ~out_valid | out_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .en          (can_load_c & ~rst),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c)
  );

  assign req_ready   = grant_c;
  assign grant_any_c = |grant_c;

  // One-hot AND-OR select of the granted nibble
  always_comb begin
    sel_nibble_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        sel_nibble_c = sel_nibble_c | req_data[i*HAM_DATA_W +: HAM_DATA_W];
      end
    end
  end

  ham_encoder u_enc (
    .data   (sel_nibble_c),
    .code_c (code7_c)
  );

`ifdef HAM_PARITY_EN
  assign code_ext_c = {^code7_c, code7_c};
`else
  assign code_ext_c = code7_c;
`endif

  // Next-state for output register, round-robin pointer and counter
  always_comb begin
    nxt_valid = out_valid;
    nxt_code  = out_code;
    nxt_src   = out_src;
    nxt_ptr   = rr_ptr;
    nxt_count = enc_count;
    if (out_valid && out_ready) begin
      nxt_count = enc_count + CNT_W'(1);
    end
    if (grant_any_c) begin
      nxt_valid = 1'b1;
      nxt_code  = code_ext_c;
      nxt_src   = grant_idx_c;
      nxt_ptr   = (grant_idx_c == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + SRC_W'(1);
    end else if (out_ready) begin
      nxt_valid = 1'b0;
    end
  end

  // State registers; reset drops any held codeword undelivered
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_code  <= '0;
      out_src   <= '0;
      enc_count <= '0;
      rr_ptr    <= '0;
    end else begin
      out_valid <= nxt_valid;
      out_code  <= nxt_code;
      out_src   <= nxt_src;
      enc_count <= nxt_count;
      rr_ptr    <= nxt_ptr;
    end
  end

endmodule

// File: tb/tb_ham_enc_arbiter.sv
// Self-checking bench for ham_enc_arbiter: randomized and directed stimulus,
// behavioural reference model feeding a scoreboard queue, separate monitor.
module tb_ham_enc_arbiter;
  import ham_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned SW   = 2;
  localparam int unsigned CW   = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ*4-1:0]          req_data;
  logic [NREQ-1:0]            req_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic [HAM_CODE_OUT_W-1:0]  out_code;
  logic [SW-1:0]              out_src;
  logic [CW-1:0]              enc_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [HAM_CODE_OUT_W-1:0] code;
    int                        src;
  } exp_t;

  exp_t q[$];

  // Reference model state
  int m_ptr = 0;
  bit m_occ = 1'b0;
  int m_cnt = 0;

`ifdef HAM_PARITY_EN
  localparam logic [HAM_CODE_OUT_W-1:0] E1011 = 8'h55;
  localparam logic [HAM_CODE_OUT_W-1:0] E0000 = 8'h00;
  localparam logic [HAM_CODE_OUT_W-1:0] E1111 = 8'hFF;
  localparam logic [HAM_CODE_OUT_W-1:0] E0001 = 8'hF0;
`else
  localparam logic [HAM_CODE_OUT_W-1:0] E1011 = 7'h55;
  localparam logic [HAM_CODE_OUT_W-1:0] E0000 = 7'h00;
  localparam logic [HAM_CODE_OUT_W-1:0] E1111 = 7'h7F;
  localparam logic [HAM_CODE_OUT_W-1:0] E0001 = 7'h70;
`endif

  ham_enc_arbiter #(
    .NUM_REQ (NREQ),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_src   (out_src),
    .enc_count (enc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Codeword from Hamming positions 1..7: parity at powers of two covers
  // every position whose index has that bit set; code[6] is position 1.
  function automatic logic [HAM_CODE_OUT_W-1:0] ref_code(input logic [3:0] nib);
    logic [7:0] pos;
    logic [6:0] c;
    logic       p;
    pos = '0;
    pos[3] = nib[0];
    pos[5] = nib[1];
    pos[6] = nib[2];
    pos[7] = nib[3];
    for (int j = 0; j < 3; j++) begin
      p = 1'b0;
      for (int b = 3; b <= 7; b++) begin
        if ((b & (1 << j)) != 0) p = p ^ pos[3'(b)];
      end
      pos[3'(1 << j)] = p;
    end
    for (int b = 1; b <= 7; b++) c[3'(7 - b)] = pos[3'(b)];
`ifdef HAM_PARITY_EN
    return {^c, c};
`else
    return c;
`endif
  endfunction

  // Reference model: predicts grants, queues expected codewords
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    int              g;
    bit              can;
    exp_t            e;
    if (rst) begin
      chk("ready_in_reset", int'(req_ready), 0);
      m_ptr = 0;
      m_occ = 1'b0;
      m_cnt = 0;
      q.delete();
    end else begin
      can     = !m_occ || out_ready;
      exp_rdy = '0;
      g       = -1;
      if (can) begin
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (m_ptr + k) % NREQ;
          if (g < 0 && req_valid[i]) g = i;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", int'(req_ready), int'(exp_rdy));
      chk("out_valid", int'(out_valid), int'(m_occ));
      chk("enc_count", int'(enc_count), m_cnt);
      if (m_occ && !out_ready && q.size() != 0) begin
        chk("stall_code", int'(out_code), int'(q[0].code));
        chk("stall_src", int'(out_src), q[0].src);
      end
      if (m_occ && out_ready) m_cnt = (m_cnt + 1) % (1 << CW);
      if (g >= 0) begin
        e.code = ref_code(req_data[g*4 +: 4]);
        e.src  = g;
        q.push_back(e);
        m_ptr = (g + 1) % NREQ;
        m_occ = 1'b1;
      end else if (out_ready) begin
        m_occ = 1'b0;
      end
    end
  end

  // Monitor: every delivered codeword must match the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_delivery", 1, 0);
      end else begin
        e = q.pop_front();
        chk("out_code", int'(out_code), int'(e.code));
        chk("out_src", int'(out_src), e.src);
      end
    end
  end

  task automatic send_one(input int idx, input logic [3:0] nib,
                          input logic [HAM_CODE_OUT_W-1:0] exp);
    int n;
    @(posedge clk); #1;
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    req_data       = '0;
    req_data[idx*4 +: 4] = nib;
    out_ready      = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[idx] && n < 20);
    chk("grant_seen", int'(req_ready[idx]), 1);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("dir_valid", int'(out_valid), 1);
    chk("dir_code", int'(out_code), int'(exp));
    chk("dir_src", int'(out_src), idx);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_code", int'(out_code), 0);
    chk("rst_src", int'(out_src), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_count", int'(enc_count), 0);

    // Single requests and known codewords
    send_one(0, 4'b1011, E1011);
    @(negedge clk);
    chk("count_after_first", int'(enc_count), 1);
    send_one(1, 4'b0000, E0000);
    send_one(2, 4'b1111, E1111);
    send_one(3, 4'b0001, E0001);

    // All requesters valid, no backpressure
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      req_valid = '1;
      req_data  = 16'($urandom);
      out_ready = 1'b1;
    end

    // Backpressure for 5 cycles, then release
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1 req_data = 16'($urandom);
    end

    // Reset while a codeword is held under backpressure
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_data  = 16'($urandom);
    out_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk("held_before_reset", int'(out_valid), 1);
    @(posedge clk); #1;
    req_valid = '0;
    rst       = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_count", int'(enc_count), 0);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 req_valid = '1;
    repeat (6) begin
      @(posedge clk); #1 req_data = 16'($urandom);
    end

    // Random traffic and backpressure; long enough to wrap the counter
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      req_valid = NREQ'($urandom_range(0, 15));
      req_data  = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
    end

    // Drain
    @(posedge clk); #1;
    req_valid = '0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
